srlatch_driver: RTL and testbench
=================================

Name: srlatch_driver

Overview:
- Synchronous initiator for the set/reset latch interface: turns single-cycle set/clear commands into the s/r level protocol the latch expects.
- Asserts exactly one of s/r, waits until the synchronized latch output q matches the target, holds, then returns s=r=0 and checks that q retains its value.
- Sits between clocked control logic and an asynchronous latch instance; reports completion and protocol errors.

Parameters:
- SYNC_STAGES, 2, flops in the q input synchronizer (>=2)
- TIMEOUT, 16, max cycles in ASSERT waiting for q_sync==target before error (>=1)
- HOLD, 2, cycles s/r stay asserted after q_sync matches (>=1)
- SETTLE, 2, cycles with s=r=0 during which q_sync must stay at target (>=1)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  command present
- req_set  in  1  command value: 1=set (drive s), 0=clear (drive r)
- req_ready  out  1  high only in IDLE
- s  out  1  latch set input, registered
- r  out  1  latch reset input, registered
- q  in  1  latch output, asynchronous to clk
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done: 1=timeout or q lost value during SETTLE
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE, s=0, r=0, done=0, err=0, busy=0, synchronizer flops=0, counters=0, target=0. req_ready=1 once rst deasserts.
- q_sync = q after SYNC_STAGES flops. All q decisions use q_sync only.
- Invariant: s and r are never 1 in the same cycle, including across transitions and reset.
- IDLE: req_ready=1. On edge with req_valid=1: latch target=req_set, go ASSERT, cnt=0. req_set is ignored when req_valid=0.
- ASSERT: s=target, r=~target, starting the cycle after acceptance.
  - Each cycle compare q_sync with target.
  - Match: go HOLD, cnt=0.
  - Otherwise cnt++. When cnt reaches TIMEOUT-1 without a match: set err_flag, go RELEASE.
  - A command that matches the current q is still fully issued. The earliest match is the first ASSERT cycle.
- HOLD: s/r unchanged for HOLD cycles, then go RELEASE, cnt=0.
- RELEASE: s=0, r=0 for SETTLE cycles.
  - If err_flag=0 and q_sync!=target in any RELEASE cycle, set err_flag.
  - After SETTLE cycles: go DONE.
- DONE: single cycle. done=1, err=err_flag. Clear err_flag, go IDLE.
  - req_ready=0 in DONE, so back-to-back commands have a 1-cycle bubble.
- Requests arriving while req_ready=0 are not accepted. The requester holds req_valid.
- Latency, no error, q responding instantly: acceptance edge, then the ASSERT window covers SYNC_STAGES delay (q_sync match at the SYNC_STAGES-th ASSERT cycle). Then HOLD, SETTLE, and DONE (1).
  - With defaults and a fast latch, done rises 2+2+2+1=7 cycles after acceptance.
- Reset mid-operation: s and r drop to 0 asynchronously, the state machine returns to IDLE, and no done pulse is generated.
- done and err are registered. err=0 whenever done=0.
- Counters are sized clog2(max(TIMEOUT,HOLD,SETTLE))+1 and must not wrap before a terminal count.

Test Plan:
- Reset, then set command with a latch model (q follows s/r after 1 cycle); q initially 0. Expected: s=1 starting cycle 1 after acceptance, r=0 throughout. done=1/err=0 exactly 7–8 cycles after acceptance (fixed by the implementation, recorded once). Then s=0 and q=1 retained.
- Clear command after set. Expected: r=1 with s=0, q goes to 0, done with err=0.
- Tie q=0 and issue a set. Expected: s stays high for exactly TIMEOUT=16 cycles, then s=0 for SETTLE=2 cycles. Then done=1, err=1.
- Latch model forgets its value when s drops (q returns to 0 in RELEASE). Expected: done=1, err=1.
- Hold req_valid=1 continuously, alternating req_set 1,0,1. Expected:
  - three completions, each separated by a 1-cycle bubble in which req_ready=0;
  - s and r never both high (assertion checked every cycle);
  - q sequence 1,0,1.
- Assert rst during HOLD of a set. Expected: s=0 in the same cycle (async), state IDLE, no done pulse. The next command completes normally.

Source files
------------

// File: rtl/srlatch_driver.sv
// Drives an external asynchronous set/reset latch: turns a one-cycle set/clear
// command into the s/r level protocol and verifies the latch took and kept the value.
module srlatch_driver #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 16,
    parameter int HOLD        = 2,
    parameter int SETTLE      = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  logic req_set,
    output logic req_ready,
    output logic s,
    output logic r,
    input  logic q,
    output logic done,
    output logic err,
    output logic busy
);

    localparam int MAX_A = (TIMEOUT > HOLD) ? TIMEOUT : HOLD;
    localparam int MAX_C = (MAX_A > SETTLE) ? MAX_A : SETTLE;
    localparam int CW    = $clog2(MAX_C) + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_HOLD,
        ST_RELEASE,
        ST_DONE
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          target_reg, target_next;
    logic          err_flag_reg, err_flag_next;
    logic          s_reg, s_next;
    logic          r_reg, r_next;
    logic          done_reg, done_next;
    logic          err_reg, err_next;
    logic          drive;
    logic          q_sync;

    // q comes from an unclocked latch, so it passes through a flop chain first.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic stage_reg;
            logic stage_d;
            if (gi == 0) begin : g_first
                assign stage_d = q;
            end else begin : g_chain
                assign stage_d = g_sync[gi-1].stage_reg;
            end
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stage_reg <= 1'b0;
                end else begin
                    stage_reg <= stage_d;
                end
            end
        end
    endgenerate

    assign q_sync = g_sync[SYNC_STAGES-1].stage_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            target_reg   <= 1'b0;
            err_flag_reg <= 1'b0;
            s_reg        <= 1'b0;
            r_reg        <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            target_reg   <= target_next;
            err_flag_reg <= err_flag_next;
            s_reg        <= s_next;
            r_reg        <= r_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        target_next   = target_reg;
        err_flag_next = err_flag_reg;

        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    target_next = req_set;
                    state_next  = ST_ASSERT;
                    cnt_next    = '0;
                end
            end
            ST_ASSERT: begin
                if (q_sync == target_reg) begin
                    state_next = ST_HOLD;
                    cnt_next   = '0;
                end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
                    err_flag_next = 1'b1;
                    state_next    = ST_RELEASE;
                    cnt_next      = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_reg == CW'(HOLD - 1)) begin
                    state_next = ST_RELEASE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            ST_RELEASE: begin
                // The latch must keep its value on its own once s/r are low.
                if (q_sync != target_reg) begin
                    err_flag_next = 1'b1;
                end
                if (cnt_reg == CW'(SETTLE - 1)) begin
                    state_next = ST_DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            ST_DONE: begin
                err_flag_next = 1'b0;
                state_next    = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase

        // Outputs are decoded from the next state so the registers line up with it;
        // s and r derive from one target bit and can never both be high.
        drive     = (state_next == ST_ASSERT) || (state_next == ST_HOLD);
        s_next    = drive & target_next;
        r_next    = drive & ~target_next;
        done_next = (state_next == ST_DONE);
        err_next  = done_next & err_flag_next;
    end

    assign s         = s_reg;
    assign r         = r_reg;
    assign done      = done_reg;
    assign err       = err_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign req_ready = (state_reg == ST_IDLE) & ~rst;

endmodule

// File: tb/tb_srlatch_driver.sv
// Bench for srlatch_driver: table-driven commands against a latch model, a
// completion scoreboard, plus back-to-back, forgetting-latch and reset sequences.
module tb_srlatch_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    // Main instance with default parameters
    logic req_valid = 1'b0, req_set = 1'b0;
    logic req_ready, s, r, q, done, err, busy;
    logic q_m = 1'b0;
    logic stuck = 1'b0;

    // Latch model: follows s/r one cycle later and stores otherwise; stuck ties q low.
    always @(posedge clk) begin
        if (s) q_m <= 1'b1;
        else if (r) q_m <= 1'b0;
    end
    assign q = stuck ? 1'b0 : q_m;

    srlatch_driver dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_set(req_set),
        .req_ready(req_ready), .s(s), .r(r), .q(q),
        .done(done), .err(err), .busy(busy)
    );

    // Second instance with a longer settle window, driving a latch that forgets
    logic req_valid2 = 1'b0, req_set2 = 1'b1;
    logic req_ready2, s2, r2, q2, done2, err2, busy2;
    logic q2_m = 1'b0;
    always @(posedge clk) q2_m <= s2;
    assign q2 = q2_m;

    srlatch_driver #(.SETTLE(4)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid2), .req_set(req_set2),
        .req_ready(req_ready2), .s(s2), .r(r2), .q(q2),
        .done(done2), .err(err2), .busy(busy2)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic err;
        logic q;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        chk("s_r_exclusive", int'(s & r), 0);
        chk("s2_r2_exclusive", int'(s2 & r2), 0);
        chk("err_without_done", int'(err & ~done), 0);
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_err", int'(err), int'(e.err));
                chk("sb_q", int'(q), int'(e.q));
            end
        end
    end

    typedef struct {
        logic set;
        logic stuck;
        logic exp_err;
        logic exp_q;
        int   exp_lat;
        int   exp_drive;
    } vec_t;

    vec_t vecs[7];

    task automatic run_cmd(input vec_t v);
        int lat;
        int drive_cnt;
        int other_cnt;
        bit got;
        @(posedge clk);
        #1 stuck = v.stuck;
        repeat (4) @(negedge clk);
        req_set   = v.set;
        req_valid = 1'b1;
        sb.push_back('{err: v.exp_err, q: v.exp_q});
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("first_drive", int'(v.set ? s : r), 1);
        chk("ready_low_when_busy", int'(req_ready), 0);
        chk("busy_after_accept", int'(busy), 1);
        drive_cnt = int'(v.set ? s : r);
        other_cnt = int'(v.set ? r : s);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) begin
                got = 1'b1;
            end else begin
                drive_cnt += int'(v.set ? s : r);
                other_cnt += int'(v.set ? r : s);
            end
        end
        chk("done_seen", int'(got), 1);
        chk("latency", lat, v.exp_lat);
        chk("drive_cycles", drive_cnt, v.exp_drive);
        chk("opposite_cycles", other_cnt, 0);
        chk("sr_low_at_done", int'(s | r), 0);
        chk("ready_low_in_done", int'(req_ready), 0);
        $display("cmd set=%0d stuck=%0d latency=%0d drive=%0d err=%0d q=%0d",
                 v.set, v.stuck, lat, drive_cnt, err, q);
    endtask

    task automatic wait_done(output bit got);
        int n;
        n = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (done) got = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1);
    end

    initial begin
        bit got;
        int lat;
        int done_cnt;
        logic qseq[3];
        vec_t after_rst;

        //          set   stuck  err   q     lat drive
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 8,  6};   // set from 0
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 8,  6};   // clear from 1
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 18, 16};  // q stuck low: timeout
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 8,  6};   // clear from 1 again
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 5,  3};   // already matches: first-cycle match
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 8,  6};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 5,  3};
        qseq[0] = 1'b1;
        qseq[1] = 1'b0;
        qseq[2] = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_s", int'(s), 0);
        chk("rst_r", int'(r), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(req_ready), 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", int'(req_ready), 1);

        for (int i = 0; i < 7; i++) begin
            run_cmd(vecs[i]);
        end

        // Latch that loses its value once s drops must be reported in the settle window.
        repeat (4) @(negedge clk);
        req_valid2 = 1'b1;
        @(posedge clk);
        #1 req_valid2 = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (done2) got = 1'b1;
        end
        chk("forget_done_seen", int'(got), 1);
        chk("forget_err", int'(err2), 1);
        chk("forget_latency", lat, 10);
        $display("cmd forget latency=%0d err=%0d", lat, err2);

        // Back-to-back with req_valid held high
        repeat (4) @(negedge clk);
        for (int k = 0; k < 3; k++) sb.push_back('{err: 1'b0, q: qseq[k]});
        req_set   = 1'b1;
        req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_done(got);
            chk("b2b_done_seen", int'(got), 1);
            chk("b2b_err", int'(err), 0);
            chk("b2b_q", int'(q), int'(qseq[k]));
            chk("b2b_bubble_ready", int'(req_ready), 0);
            $display("cmd b2b idx=%0d q=%0d err=%0d", k, q, err);
            if (k < 2) begin
                req_set = qseq[k+1];
                @(posedge clk);
                #1;
                chk("b2b_ready_idle", int'(req_ready), 1);
                @(posedge clk);
                #1;
                chk("b2b_busy_next", int'(busy), 1);
            end else begin
                req_valid = 1'b0;
            end
        end

        // Reset during HOLD of a set (q is already 1, so HOLD starts one cycle after acceptance)
        repeat (4) @(negedge clk);
        req_set   = 1'b1;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("hold_s_high", int'(s), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_s", int'(s), 0);
        chk("async_rst_r", int'(r), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_ready", int'(req_ready), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            done_cnt += int'(done);
        end
        chk("no_done_after_rst", done_cnt, 0);
        chk("idle_after_rst", int'(busy), 0);
        $display("cmd reset_in_hold done_pulses=%0d", done_cnt);

        after_rst = '{1'b0, 1'b0, 1'b0, 1'b0, 8, 6};
        run_cmd(after_rst);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
